switch_box_config_loader: RTL and testbench

SWITCH_BOX_CONFIG_LOADER -- requirements
Module: switch_box_config_loader

---
 rtl/switch_box_config_loader.sv | 144 ++++++++++++++
 tb/tb_switch_box_config_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_box_config_loader.sv
// Serial loader that shifts a configuration frame into a shadow register and commits it to a switch box in one step.
// Define CFG_PARITY_EN to append one even-parity bit per frame and flag a sticky err when the parity check fails.
module switch_box_config_loader #(
   parameter int WS = 7,
   parameter int WD = 6
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cfg_start,
   input  logic                          cfg_in,
   input  logic                          cfg_valid,
   output logic                          cfg_ready,
   output logic [WS*6+(WD/2)*6-1:0]      c,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [1:0]                    state_dbg
);

   localparam int CW    = WS*6 + (WD/2)*6;
   localparam int CNT_W = $clog2(CW+1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
`ifdef CFG_PARITY_EN
      ,PARITY = 2'd3
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CW-1:0]    shadow_q, shadow_d;
   logic [CW-1:0]    c_q, c_d;
   logic             par_q, par_d;
   logic             done_q, done_d;
`ifdef CFG_PARITY_EN
   logic             err_q, err_d;
`endif

   // Handshake: a bit is taken on a rising edge where cfg_valid && cfg_ready;
   // cfg_start in SHIFT/PARITY wins over a same-cycle bit, which is dropped.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shadow_d  = shadow_q;
      c_d       = c_q;
      par_d     = par_q;
      done_d    = 1'b0;
      cfg_ready = 1'b0;
`ifdef CFG_PARITY_EN
      err_d     = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (cfg_start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               par_d   = 1'b0;
`ifdef CFG_PARITY_EN
               err_d   = 1'b0;
`endif
            end
         end
         SHIFT: begin
            cfg_ready = 1'b1;
            if (cfg_start) begin
               cnt_d = '0;
               par_d = 1'b0;
            end else if (cfg_valid) begin
               shadow_d = {cfg_in, shadow_q[CW-1:1]};
               cnt_d    = cnt_q + 1'b1;
               par_d    = par_q ^ cfg_in;
               if (cnt_q == CNT_W'(CW-1)) begin
`ifdef CFG_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = COMMIT;
`endif
               end
            end
         end
`ifdef CFG_PARITY_EN
         PARITY: begin
            cfg_ready = 1'b1;
            if (cfg_start) begin
               state_d = SHIFT;
               cnt_d   = '0;
               par_d   = 1'b0;
            end else if (cfg_valid) begin
               if ((par_q ^ cfg_in) == 1'b0) begin
                  state_d = COMMIT;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
`endif
         COMMIT: begin
            c_d     = shadow_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         c_q      <= '0;
         par_q    <= 1'b0;
         done_q   <= 1'b0;
`ifdef CFG_PARITY_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         c_q      <= c_d;
         par_q    <= par_d;
         done_q   <= done_d;
`ifdef CFG_PARITY_EN
         err_q    <= err_d;
`endif
      end
   end

   assign c         = c_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign state_dbg = state_q;
`ifdef CFG_PARITY_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_switch_box_config_loader.sv
// Directed bench for switch_box_config_loader: stimulus pushes expected commits, a negedge monitor pops and compares.
module tb_switch_box_config_loader;

   localparam int CW = 60;

   logic          clk;
   logic          rst_n;
   logic          cfg_start;
   logic          cfg_in;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [CW-1:0] c;
   logic          busy;
   logic          done;
   logic          err;
   logic [1:0]    state_dbg;

   logic [CW-1:0] exp_q[$];
   int            n_vec = 0;
   int            n_err = 0;
   bit            sim_end = 0;

   switch_box_config_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_start (cfg_start),
      .cfg_in    (cfg_in),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .c         (c),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .state_dbg (state_dbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      check("ready_after_start", 64'(cfg_ready), 64'd1);
   endtask

   // Sends CW data bits (plus a parity bit when enabled); gaps inserts an idle cycle before each beat.
   task automatic send_bits(input logic [CW-1:0] d, input bit gaps, input logic pbit);
      for (int j = 0; j < CW; j++) begin
         if (gaps) begin
            cfg_valid = 1'b0;
            tick();
         end
         if (j == CW-1) check("ready_before_last", 64'(cfg_ready), 64'd1);
         cfg_valid = 1'b1;
         cfg_in    = d[j];
         tick();
      end
`ifdef CFG_PARITY_EN
      cfg_valid = 1'b1;
      cfg_in    = pbit;
      tick();
`else
      if (pbit !== 1'b0) $display("note: parity bit ignored in this build");
`endif
      cfg_valid = 1'b0;
      cfg_in    = 1'b0;
   endtask

   task automatic settle_idle();
      int k;
      k = 0;
      while (busy && k < 10) begin
         tick();
         k++;
      end
      tick();
      tick();
      check("busy_after_frame", 64'(busy), 64'd0);
      check("ready_after_frame", 64'(cfg_ready), 64'd0);
   endtask

   task automatic full_frame(input logic [CW-1:0] d, input bit gaps);
      exp_q.push_back(d);
      start_frame();
      send_bits(d, gaps, ^d);
      settle_idle();
      check("err_clean_frame", 64'(err), 64'd0);
   endtask

   // Monitor: c may only move on a done cycle, and then must equal the oldest expected commit.
   initial begin : monitor
      logic [CW-1:0] c_model;
      logic          done_prev;
      c_model   = '0;
      done_prev = 1'b0;
      while (!sim_end) begin
         @(negedge clk);
         if (!rst_n) begin
            c_model   = '0;
            done_prev = 1'b0;
         end else begin
            check("done_one_cycle", 64'(done & done_prev), 64'd0);
            if (done) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", 64'd1, 64'd0);
               end else begin
                  c_model = exp_q.pop_front();
                  check("c_commit", 64'(c), 64'(c_model));
               end
            end else begin
               check("c_hold", 64'(c), 64'(c_model));
            end
            done_prev = done;
         end
      end
   end

   initial begin : stimulus
      logic [CW-1:0] ones;
      logic [CW-1:0] alt;
      logic [CW-1:0] pat;
      ones      = '1;
      alt       = 60'hAAAAAAAAAAAAAAA;
      pat       = 60'h123456789ABCDEF;
      rst_n     = 1'b0;
      cfg_start = 1'b0;
      cfg_in    = 1'b0;
      cfg_valid = 1'b0;
      repeat (3) tick();
      check("rst_c", 64'(c), 64'd0);
      check("rst_ready", 64'(cfg_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      rst_n = 1'b1;
      tick();

      full_frame(alt, 1'b0);

      // Abort after 30 ones; the restart cycle also carries a 0 bit that must be dropped.
      exp_q.push_back(ones);
      start_frame();
      for (int j = 0; j < 30; j++) begin
         cfg_valid = 1'b1;
         cfg_in    = 1'b1;
         tick();
      end
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_in    = 1'b0;
      tick();
      cfg_start = 1'b0;
      check("busy_after_abort", 64'(busy), 64'd1);
      send_bits(ones, 1'b0, 1'b0);
      settle_idle();

      full_frame(alt, 1'b1);

      // Asynchronous reset mid-frame, sampled between clock edges.
      start_frame();
      for (int j = 0; j < 20; j++) begin
         cfg_valid = 1'b1;
         cfg_in    = 1'b1;
         tick();
      end
      cfg_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_c", 64'(c), 64'd0);
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_ready", 64'(cfg_ready), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      full_frame(pat, 1'b0);

`ifdef CFG_PARITY_EN
      start_frame();
      send_bits(ones, 1'b0, 1'b1);
      settle_idle();
      check("parity_err_set", 64'(err), 64'd1);
      check("parity_c_kept", 64'(c), 64'(pat));
      start_frame();
      check("err_cleared_on_start", 64'(err), 64'd0);
      exp_q.push_back(ones);
      send_bits(ones, 1'b0, 1'b0);
      settle_idle();
      check("parity_good_err", 64'(err), 64'd0);
`endif

      repeat (5) tick();
      check("exp_q_drained", 64'(exp_q.size()), 64'd0);
      sim_end = 1'b1;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
